// File: rtl/fifo_axis_serializer.sv
// fifo_axis_serializer
// Drains wide packet words from a standard-read FIFO and serializes each word
// into narrow AXI4-Stream beats, carrying packet boundaries through tlast.
// Storage: NXT landing register + CUR word under serialization (lane idx).
// Optional build macro: FIFO_AXIS_SER_PKT_CNT_EN adds the pkt_cnt port/counter.
module fifo_axis_serializer #(
    parameter int IN_DATA_WIDTH  = 256,
    parameter int OUT_DATA_WIDTH = 64
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [IN_DATA_WIDTH+IN_DATA_WIDTH/8:0] fifo_dout,
    input  logic                                   fifo_empty,
    output logic                                   fifo_rd_en,
    output logic [OUT_DATA_WIDTH-1:0]              m_axis_tdata,
    output logic [OUT_DATA_WIDTH/8-1:0]            m_axis_tkeep,
    output logic                                   m_axis_tlast,
    output logic                                   m_axis_tvalid,
    input  logic                                   m_axis_tready
`ifdef FIFO_AXIS_SER_PKT_CNT_EN
    ,
    output logic [31:0]                            pkt_cnt
`endif
);

    localparam int R  = IN_DATA_WIDTH / OUT_DATA_WIDTH;
    localparam int KI = IN_DATA_WIDTH / 8;
    localparam int KO = OUT_DATA_WIDTH / 8;
    localparam int IW = (R > 1) ? $clog2(R) : 1;

    typedef enum logic {S_IDLE, S_ACTIVE} state_t;

    state_t                      r_state, w_state_nxt;
    logic                        r_inflight;
    logic                        r_nxt_vld;
    logic [IN_DATA_WIDTH+KI:0]   r_nxt;
    logic [IN_DATA_WIDTH-1:0]    r_cur_data;
    logic [KI-1:0]               r_cur_keep;
    logic                        r_cur_last;
    logic [IW-1:0]               r_idx;
    logic [IW-1:0]               r_fl;

    logic                        w_nxt_vld;
    logic [IN_DATA_WIDTH+KI:0]   w_nxt_word;
    logic [IN_DATA_WIDTH-1:0]    w_nxt_data;
    logic [KI-1:0]               w_nxt_keep;
    logic                        w_nxt_last;
    logic [IW-1:0]               w_nxt_fl;
    logic                        w_hs;
    logic                        w_final;
    logic                        w_load;

    // Data returning from an in-flight read counts as NXT for that cycle and is
    // forwarded straight into CUR when CUR is free; this is what gives the
    // two-cycle empty-to-tvalid latency and bubble-free word boundaries at R=2.
    assign w_nxt_vld  = r_nxt_vld | r_inflight;
    assign w_nxt_word = r_nxt_vld ? r_nxt : fifo_dout;
    assign w_nxt_data = w_nxt_word[IN_DATA_WIDTH-1:0];
    assign w_nxt_keep = w_nxt_word[IN_DATA_WIDTH +: KI];
    assign w_nxt_last = w_nxt_word[IN_DATA_WIDTH+KI];

    assign fifo_rd_en = !rst && !fifo_empty && !r_nxt_vld && !r_inflight;

    assign w_hs    = m_axis_tvalid && m_axis_tready;
    assign w_final = w_hs && (r_idx == r_fl);
    assign w_load  = w_nxt_vld && ((r_state == S_IDLE) || w_final);

    // Final lane of the incoming word: highest lane with any keep bit on a last word.
    always_comb begin
        w_nxt_fl = IW'(R - 1);
        if (w_nxt_last) begin
            w_nxt_fl = '0;
            for (int l = 0; l < R; l++)
                if (|w_nxt_keep[l*KO +: KO]) w_nxt_fl = IW'(l);
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next state: a load always leaves CUR active; finishing without a load idles.
    always_comb begin
        w_state_nxt = r_state;
        if (w_load)       w_state_nxt = S_ACTIVE;
        else if (w_final) w_state_nxt = S_IDLE;
    end

    // Outputs: present lane idx of CUR.
    always_comb begin
        m_axis_tvalid = (r_state == S_ACTIVE);
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        for (int l = 0; l < R; l++) begin
            if (r_idx == IW'(l)) begin
                m_axis_tdata = r_cur_data[l*OUT_DATA_WIDTH +: OUT_DATA_WIDTH];
                m_axis_tkeep = r_cur_keep[l*KO +: KO];
            end
        end
        m_axis_tlast = m_axis_tvalid && r_cur_last && (r_idx == r_fl);
    end

    // Read tracking, NXT landing register and CUR word/lane index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inflight <= 1'b0;
            r_nxt_vld  <= 1'b0;
            r_nxt      <= '0;
            r_cur_data <= '0;
            r_cur_keep <= '0;
            r_cur_last <= 1'b0;
            r_idx      <= '0;
            r_fl       <= '0;
        end else begin
            r_inflight <= fifo_rd_en;
            if (r_inflight && !w_load) begin
                r_nxt     <= fifo_dout;
                r_nxt_vld <= 1'b1;
            end else if (w_load) begin
                r_nxt_vld <= 1'b0;
            end
            if (w_load) begin
                r_cur_data <= w_nxt_data;
                r_cur_keep <= w_nxt_keep;
                r_cur_last <= w_nxt_last;
                r_fl       <= w_nxt_fl;
                r_idx      <= '0;
            end else if (w_hs) begin
                r_idx      <= r_idx + 1'b1;
            end
        end
    end

`ifdef FIFO_AXIS_SER_PKT_CNT_EN
    logic [31:0] r_pkt_cnt;

    // Count packets on each accepted tlast beat; wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     r_pkt_cnt <= '0;
        else if (w_hs && m_axis_tlast) r_pkt_cnt <= r_pkt_cnt + 32'd1;
    end

    assign pkt_cnt = r_pkt_cnt;
`endif

endmodule

// File: tb/tb_fifo_axis_serializer.sv
// Testbench for fifo_axis_serializer: FIFO model, beat-level reference model
// built from word/keep rules, per-cycle protocol and data checks.
module tb_fifo_axis_serializer;
    localparam int IN  = 256;
    localparam int OUT = 64;
    localparam int R   = IN / OUT;
    localparam int KI  = IN / 8;
    localparam int KO  = OUT / 8;
    localparam int FW  = IN + KI + 1;

    logic            clk = 1'b0;
    logic            rst;
    logic [FW-1:0]   fifo_dout;
    logic            fifo_empty;
    logic            fifo_rd_en;
    logic [OUT-1:0]  tdata;
    logic [KO-1:0]   tkeep;
    logic            tlast, tvalid, tready;
`ifdef FIFO_AXIS_SER_PKT_CNT_EN
    logic [31:0]     pkt_cnt;
`endif

    always #5 clk = ~clk;

    fifo_axis_serializer #(.IN_DATA_WIDTH(IN), .OUT_DATA_WIDTH(OUT)) dut (
        .clk(clk), .rst(rst),
        .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .m_axis_tdata(tdata), .m_axis_tkeep(tkeep), .m_axis_tlast(tlast),
        .m_axis_tvalid(tvalid), .m_axis_tready(tready)
`ifdef FIFO_AXIS_SER_PKT_CNT_EN
        , .pkt_cnt(pkt_cnt)
`endif
    );

    typedef struct packed {
        logic [OUT-1:0] d;
        logic [KO-1:0]  k;
        logic           l;
        logic           fin;
    } beat_t;

    logic [FW-1:0] fq[$];
    beat_t         eq[$];

    int checks = 0, errors = 0, cyc = 0;
    int popped = 0, done_w = 0, ready_pct = 100;
    bit pop_req = 0, idle_chk = 0, p_stall = 0;
    logic [OUT-1:0] p_d;
    logic [KO-1:0]  p_k;
    logic           p_l;
    logic           s_rd, s_v;
    int hs_cnt, hs_first_cyc, hs_last_cyc;
    logic [KO-1:0]  hs_last_keep;
    logic           hs_last_last;
    logic [OUT-1:0] hs_last_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic reset_stats();
        hs_cnt = 0; hs_first_cyc = -1; hs_last_cyc = -1;
        hs_last_keep = '0; hs_last_last = 1'b0; hs_last_data = '0;
    endtask

    // FIFO write plus expected beats derived from the word's last/keep fields.
    task automatic push_word(input logic [IN-1:0] data, input logic [KI-1:0] keep, input logic last);
        int fl;
        beat_t b;
        fq.push_back({last, keep, data});
        fifo_empty = 1'b0;
        fl = R - 1;
        if (last) begin
            fl = 0;
            for (int l = 0; l < R; l++) if (keep[l*KO +: KO] != 0) fl = l;
        end
        for (int l = 0; l <= fl; l++) begin
            b.d = data[l*OUT +: OUT];
            b.k = keep[l*KO +: KO];
            b.l = last && (l == fl);
            b.fin = (l == fl);
            eq.push_back(b);
        end
    endtask

    function automatic logic [IN-1:0] rand_data();
        logic [IN-1:0] d;
        for (int i = 0; i < IN/32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    // One cycle: check outputs mid-cycle, then service the FIFO model after the edge.
    task automatic step();
        beat_t b;
        @(negedge clk);
        cyc++;
        s_rd = fifo_rd_en; s_v = tvalid;
        if (rst) begin
            p_stall = 0; pop_req = 0;
        end else begin
            if (p_stall) begin
                checks++;
                if (!(tvalid === 1'b1 && tdata === p_d && tkeep === p_k && tlast === p_l)) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%0b d=%0h k=%0h l=%0b want v=1 d=%0h k=%0h l=%0b",
                             tvalid, tdata, tkeep, tlast, p_d, p_k, p_l);
                end
            end
            if (fifo_rd_en) begin
                checks++;
                if (fifo_empty || popped != done_w + (tvalid ? 1 : 0)) begin
                    errors++;
                    $display("FAIL pop_rule: got empty=%0b pending=%0d want empty=0 pending=0",
                             fifo_empty, popped - done_w - (tvalid ? 1 : 0));
                end
            end
            if (idle_chk) begin
                chk("idle_rd_en", fifo_rd_en, 0);
                chk("idle_tvalid", tvalid, 0);
            end
            if (tvalid && tready) begin
                if (eq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_beat: got d=%0h want no beat", tdata);
                end else begin
                    b = eq.pop_front();
                    chk("beat_data", tdata, b.d);
                    chk("beat_keep", tkeep, b.k);
                    chk("beat_last", tlast, b.l);
                    if (b.fin) done_w++;
                end
                hs_cnt++;
                if (hs_first_cyc < 0) hs_first_cyc = cyc;
                hs_last_cyc = cyc; hs_last_keep = tkeep; hs_last_last = tlast; hs_last_data = tdata;
            end
            p_stall = tvalid && !tready;
            p_d = tdata; p_k = tkeep; p_l = tlast;
            pop_req = fifo_rd_en;
        end
        @(posedge clk);
        #1;
        if (pop_req) begin
            popped++;
            if (fq.size() == 0) begin
                checks++; errors++;
                $display("FAIL pop_underflow: got pop want none (fifo empty)");
            end else begin
                fifo_dout = fq.pop_front();
            end
        end
        fifo_empty = (fq.size() == 0);
        tready = ($urandom_range(99) < ready_pct);
    endtask

    task automatic drain();
        int n = 0;
        while ((fq.size() != 0 || eq.size() != 0) && n < 3000) begin
            step(); n++;
        end
        if (n >= 3000) begin
            checks++; errors++;
            $display("FAIL drain_timeout: got %0d beats left want 0", eq.size());
        end
        repeat (3) step();
    endtask

    logic [IN-1:0] w0, w1;

    initial begin
        rst = 1'b1; tready = 1'b1; fifo_empty = 1'b0; fifo_dout = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rd_en", fifo_rd_en, 0);
        chk("rst_tvalid", tvalid, 0);
        chk("rst_tlast", tlast, 0);
        chk("rst_tdata", tdata, 0);
        chk("rst_tkeep", tkeep, 0);
`ifdef FIFO_AXIS_SER_PKT_CNT_EN
        chk("rst_pkt_cnt", pkt_cnt, 0);
`endif
        fifo_empty = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        step();

        // Non-last word followed by a last word covering two lanes.
        w1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
              64'h1111_2222_3333_4444, 64'h0000_0000_0000_0001};
        reset_stats();
        push_word(rand_data(), '1, 1'b0);
        push_word(w1, 32'h0000_FFFF, 1'b1);
        drain();
        chk("t1_beats", hs_cnt, 6);
        chk("t1_last_keep", hs_last_keep, 8'hFF);
        chk("t1_last_tlast", hs_last_last, 1);
        chk("t1_last_data", hs_last_data, 64'h1111_2222_3333_4444);
        chk("t1_no_bubble", hs_last_cyc - hs_first_cyc, 5);

        // Single-byte and empty-keep last words.
        reset_stats();
        push_word(rand_data(), 32'h0000_0001, 1'b1);
        drain();
        chk("t2a_beats", hs_cnt, 1);
        chk("t2a_keep", hs_last_keep, 8'h01);
        chk("t2a_tlast", hs_last_last, 1);
        reset_stats();
        push_word(rand_data(), 32'h0000_0000, 1'b1);
        drain();
        chk("t2b_beats", hs_cnt, 1);
        chk("t2b_keep", hs_last_keep, 8'h00);
        chk("t2b_tlast", hs_last_last, 1);

        // Empty FIFO for 50 cycles, then the two-cycle start-up latency.
        idle_chk = 1;
        repeat (50) step();
        idle_chk = 0;
        push_word(rand_data(), '1, 1'b0);
        step();
        chk("lat_c0_rd_en", s_rd, 1);
        chk("lat_c0_tvalid", s_v, 0);
        step();
        chk("lat_c1_tvalid", s_v, 0);
        step();
        chk("lat_c2_tvalid", s_v, 1);
        drain();

        // Reset while lane 2 is shown and the next word's read is in flight.
        w0 = {64'hD0D0_D0D0_D0D0_D0D0, 64'hC0C0_C0C0_C0C0_C0C0,
              64'hB0B0_B0B0_B0B0_B0B0, 64'hA0A0_A0A0_A0A0_A0A0};
        push_word(w0, '1, 1'b0);
        repeat (3) step();
        push_word(rand_data(), '1, 1'b1);
        step();
        chk("rm_pop", s_rd, 1);
        #2;
        chk("rm_pre_tvalid", tvalid, 1);
        chk("rm_pre_lane2", tdata, 64'hC0C0_C0C0_C0C0_C0C0);
        rst = 1'b1;
        #1;
        chk("rm_tvalid", tvalid, 0);
        chk("rm_tlast", tlast, 0);
        chk("rm_tdata", tdata, 0);
        chk("rm_tkeep", tkeep, 0);
        chk("rm_rd_en", fifo_rd_en, 0);
        fq.delete(); eq.delete();
        popped = 0; done_w = 0; fifo_empty = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        repeat (10) step();
        chk("rm_after_tvalid", tvalid, 0);

        // Randomized backpressure over 100 words.
        ready_pct = 50;
        for (int i = 0; i < 100; i++) begin
            logic last;
            logic [KI-1:0] keep;
            last = ($urandom_range(3) == 0);
            keep = '1;
            if (last) begin
                case ($urandom_range(3))
                    0:       keep = '0;
                    1:       keep = KI'(1) << $urandom_range(KI - 1);
                    default: keep = KI'($urandom);
                endcase
            end
            push_word(rand_data(), keep, last);
            repeat ($urandom_range(3)) step();
        end
        drain();

`ifdef FIFO_AXIS_SER_PKT_CNT_EN
        // Packet counter wrap.
        ready_pct = 100;
        force dut.r_pkt_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.r_pkt_cnt;
        for (int i = 0; i < 3; i++) push_word(rand_data(), 32'h0000_00FF, 1'b1);
        drain();
        chk("pkt_cnt_wrap", pkt_cnt, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "timeout");
    end
endmodule
